// File: rtl/io_uart_tx_pkg.sv
// Shared FSM encoding and framing constants for the I/O UART transmitter.
// Encodings match the values the CPU-side debug tooling expects.
package io_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_BYTES_PER_WORD = 8;
  localparam int UART_FRAME_BITS     = 10;

endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
// Latency: one cycle from push to non-empty. Backpressure: none, caller sees full.
// Overflowing pushes are silently discarded; the caller flags them.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Buffers 64-bit CPU I/O writes and sends each as eight LSB-first 8N1 frames.
// Latency: start bit begins two edges after the write. Backpressure: none, drops set overflow.
// The CPU never stalls; words arriving while the FIFO is full are lost.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          io_write,
  input  logic [63:0]                   io_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int             BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BYTE_LAST = 3'(UART_BYTES_PER_WORD - 1);

  uart_state_t  state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]   bit_idx;
  logic [2:0]   byte_idx;
  logic [63:0]  shreg;
  logic [63:0]  fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         baud_end;
  logic         pop;
  logic [7:0]   cur_byte;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign cur_byte = shreg[7:0];
  // A new word is taken either from idle or exactly at the last stop bit's end.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) ||
                (state == ST_STOP && baud_end && byte_idx == BYTE_LAST));

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io_write),
    .pop   (pop),
    .din   (io_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      if (io_write && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            byte_idx <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_START;
          end else begin
            tx   <= 1'b1;
            busy <= io_write;
          end
        end

        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= cur_byte[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx != BYTE_LAST) begin
              shreg    <= {8'h00, shreg[63:8]};
              byte_idx <= byte_idx + 3'd1;
              tx       <= 1'b0;
              state    <= ST_START;
            end else if (!fifo_empty) begin
              shreg    <= fifo_dout;
              byte_idx <= '0;
              tx       <= 1'b0;
              state    <= ST_START;
            end else begin
              tx    <= 1'b1;
              busy  <= io_write;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed and random stimulus against a word-level timing model of the UART output.
module tb_io_uart_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int WORD_CYC = 80 * CPB;
  localparam int FRAME_CYC = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          io_write = 1'b0;
  logic [63:0]   io_data = '0;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_write (io_write),
    .io_data  (io_data),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .level    (level)
  );

  // Model: queue of pending words plus cycles left on the word being sent.
  logic [63:0] mq[$];
  logic [63:0] cur_word = '0;
  int          rem = 0;
  bit          m_ovf = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int max_level = 0;

  function automatic logic exp_tx();
    int p, f, b;
    if (rem == 0) return 1'b1;
    p = WORD_CYC - rem;
    f = p / FRAME_CYC;
    b = (p % FRAME_CYC) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_word[f*8 + b - 1];
  endfunction

  task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      rem   = 0;
      m_ovf = 1'b0;
    end else begin
      if (mq.size() > 0 && rem <= 1) begin
        cur_word = mq.pop_front();
        rem      = WORD_CYC;
      end else if (rem > 0) begin
        rem--;
      end
      if (io_write) begin
        if (mq.size() < DEPTH) mq.push_back(io_data);
        else m_ovf = 1'b1;
      end
    end
    #1;
    check1("tx", tx, exp_tx());
    check1("busy", busy, (rem > 0 || mq.size() > 0));
    check1("level", level, mq.size());
    check1("overflow", overflow, m_ovf);
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic write_word(input logic [63:0] d);
    io_write = 1'b1;
    io_data  = d;
    tick();
    io_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && !(rem == 0 && mq.size() == 0); i++) tick();
    check1("drain_busy", busy, 1'b0);
  endtask

  logic [9:0] a5_pat;

  initial begin
    // Reset state
    pulse_reset();
    check1("rst_tx", tx, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_level", level, 0);
    check1("rst_ovf", overflow, 1'b0);

    // Single word: tx low after E+1, idle again after E+1+WORD_CYC
    write_word(64'h0123456789ABCDEF);
    check1("single_level", level, 1);
    tick();
    check1("single_start", tx, 1'b0);
    idle(WORD_CYC);
    check1("single_end_tx", tx, 1'b1);
    check1("single_end_busy", busy, 1'b0);

    // Back-to-back words: sixteen gapless frames
    write_word({8{8'h11}});
    write_word({8{8'h22}});
    idle(2 * WORD_CYC);
    check1("b2b_end_busy", busy, 1'b0);

    // Full FIFO with a write in the cycle of the final-stop pop
    write_word(64'hA0A0_A0A0_A0A0_A0A0);
    for (int i = 0; i < DEPTH; i++) write_word(64'hF000_0000_0000_0000 | 64'(i));
    check1("fill_level", level, DEPTH);
    for (int i = 0; i < 2 * WORD_CYC && rem != 1; i++) tick();
    write_word(64'hBBBB_BBBB_BBBB_BBBB);
    check1("simul_ovf", overflow, 1'b0);
    check1("simul_level", level, DEPTH);
    drain();

    // Overflow: six consecutive writes from idle
    max_level = 0;
    for (int i = 0; i < 6; i++) write_word(64'h5555_0000_0000_0000 | 64'(i));
    check1("ovf_set", overflow, 1'b1);
    drain();
    check1("ovf_sticky", overflow, 1'b1);
    check1("ovf_peak", max_level, DEPTH);

    // Reset during a data bit
    pulse_reset();
    write_word(64'hCAFE_F00D_DEAD_BEEF);
    idle(3 * CPB);
    pulse_reset();
    check1("mid_tx", tx, 1'b1);
    check1("mid_busy", busy, 1'b0);
    check1("mid_level", level, 0);
    check1("mid_ovf", overflow, 1'b0);
    write_word(64'h8765_4321_0FED_CBA9);
    drain();

    // Bit timing of 0xA5 frame
    a5_pat = 10'b1101001010;
    write_word(64'h0000_0000_0000_00A5);
    tick();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        check1("a5_bit", tx, a5_pat[b]);
        tick();
      end
    end
    drain();

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        io_write = 1'b0;
        pulse_reset();
      end else begin
        io_write = ($urandom_range(0, 99) < 3);
        io_data  = {$urandom, $urandom};
        tick();
      end
    end
    io_write = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
